// File: rtl/i2c_txn_if.sv
// Requester and engine signal bundle for the shared I2C transaction engine arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus engine.
interface i2c_txn_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_wr;
  logic [32*NREQ-1:0] req_wdata;
  logic [32*NREQ-1:0] req_rdata;
  logic [5*NREQ-1:0]  req_nm;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    req_done;
  logic [NREQ-1:0]    req_err;
  logic               bus_en;
  logic               bus_wr;
  logic [31:0]        bus_wdata;
  logic [31:0]        bus_rdata;
  logic [4:0]         bus_nm;
  logic               bus_done;
  logic               bus_error;

  modport master (
    input  req_valid, req_wr, req_wdata, req_rdata, req_nm, bus_done, bus_error,
    output grant, req_done, req_err, bus_en, bus_wr, bus_wdata, bus_rdata, bus_nm
  );

  modport slave (
    output req_valid, req_wr, req_wdata, req_rdata, req_nm, bus_done, bus_error,
    input  grant, req_done, req_err, bus_en, bus_wr, bus_wdata, bus_rdata, bus_nm
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C transaction engine among NREQ requesters.
// The grant is held until engine done/error or a watchdog abort, then the owner gets a one-cycle status pulse.
module i2c_txn_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk_in,
  input  logic       reset_n,
  i2c_txn_if.master  ifc,
  output logic       busy,
  output logic [7:0] timeout_cnt
);
  localparam int               IDX_W     = $clog2(NREQ);
  localparam logic [15:0]      WDOG_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [NREQ-1:0]  err_q, err_d;
  logic             bus_en_q, bus_en_d;
  logic             bus_wr_q, bus_wr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [31:0]      bus_rdata_q, bus_rdata_d;
  logic [4:0]       bus_nm_q, bus_nm_d;
  logic [15:0]      wdog_q, wdog_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic             busy_q, busy_d;

  logic             win_found_s;
  logic [IDX_W-1:0] win_idx_s;
  logic [IDX_W-1:0] cand_s;
  logic [NREQ-1:0]  win_onehot_s;
  logic             sel_wr_s;
  logic [31:0]      sel_wdata_s;
  logic [31:0]      sel_rdata_s;
  logic [4:0]       sel_nm_s;

  // Round-robin pick: first active requester after the last winner, plus its command fields.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = last_q;
    cand_s      = last_q;
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = IDX_W'((int'(last_q) + i) % NREQ);
      if (!win_found_s && ifc.req_valid[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
    win_onehot_s = '0;
    sel_wr_s     = 1'b0;
    sel_wdata_s  = 32'h0000_0000;
    sel_rdata_s  = 32'h0000_0000;
    sel_nm_s     = 5'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx_s == IDX_W'(i)) begin
        win_onehot_s[i] = 1'b1;
        sel_wr_s        = ifc.req_wr[i];
        sel_wdata_s     = ifc.req_wdata[32*i +: 32];
        sel_rdata_s     = ifc.req_rdata[32*i +: 32];
        sel_nm_s        = ifc.req_nm[5*i +: 5];
      end else begin
        win_onehot_s[i] = 1'b0;
      end
    end
  end

  // Transaction FSM: next state plus every registered output.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    done_d      = '0;
    err_d       = '0;
    bus_en_d    = bus_en_q;
    bus_wr_d    = bus_wr_q;
    bus_wdata_d = bus_wdata_q;
    bus_rdata_d = bus_rdata_q;
    bus_nm_d    = bus_nm_q;
    wdog_d      = wdog_q;
    tcnt_d      = tcnt_q;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          grant_d     = win_onehot_s;
          bus_wr_d    = sel_wr_s;
          bus_wdata_d = sel_wdata_s;
          bus_rdata_d = sel_rdata_s;
          bus_nm_d    = sel_nm_s;
          last_d      = win_idx_s;
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        bus_en_d = 1'b1;
        wdog_d   = 16'd0;
        state_d  = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + 16'd1;
        // Error wins over done; the watchdog only fires when the engine is silent.
        if (ifc.bus_error) begin
          err_d    = grant_q;
          bus_en_d = 1'b0;
          grant_d  = '0;
          state_d  = RELEASE;
        end else if (ifc.bus_done) begin
          done_d   = grant_q;
          bus_en_d = 1'b0;
          grant_d  = '0;
          state_d  = RELEASE;
        end else if (wdog_q == WDOG_LAST) begin
          err_d    = grant_q;
          bus_en_d = 1'b0;
          grant_d  = '0;
          tcnt_d   = (tcnt_q == 8'hFF) ? 8'hFF : tcnt_q + 8'd1;
          state_d  = RELEASE;
        end else begin
          state_d = WAIT;
        end
      end
      RELEASE: begin
        grant_d = '0;
        if (!ifc.bus_done && !ifc.bus_error) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        grant_d  = '0;
        bus_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= LAST_RST;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      bus_en_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_wdata_q <= 32'h0000_0000;
      bus_rdata_q <= 32'h0000_0000;
      bus_nm_q    <= 5'd0;
      wdog_q      <= 16'd0;
      tcnt_q      <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      bus_en_q    <= bus_en_d;
      bus_wr_q    <= bus_wr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_rdata_q <= bus_rdata_d;
      bus_nm_q    <= bus_nm_d;
      wdog_q      <= wdog_d;
      tcnt_q      <= tcnt_d;
      busy_q      <= busy_d;
    end
  end

  assign ifc.grant     = grant_q;
  assign ifc.req_done  = done_q;
  assign ifc.req_err   = err_q;
  assign ifc.bus_en    = bus_en_q;
  assign ifc.bus_wr    = bus_wr_q;
  assign ifc.bus_wdata = bus_wdata_q;
  assign ifc.bus_rdata = bus_rdata_q;
  assign ifc.bus_nm    = bus_nm_q;
  assign busy          = busy_q;
  assign timeout_cnt   = tcnt_q;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: a round-robin reference model queues expected grants and
// status pulses, an engine process answers bus_en, and a monitor compares whatever the DUT presents.
module tb_i2c_txn_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 20;

  logic       clk_in  = 1'b0;
  logic       reset_n = 1'b0;
  logic       busy;
  logic [7:0] timeout_cnt;

  i2c_txn_if #(.NREQ(NREQ)) ifc ();

  i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .ifc         (ifc),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [NREQ-1:0] grant; logic wr; logic [31:0] wdata; logic [31:0] rdata; logic [4:0] nm; } gexp_t;
  typedef struct { logic [NREQ-1:0] done; logic [NREQ-1:0] err; logic [7:0] tcnt; } sexp_t;
  typedef struct { int kind; int delay; int hold; } plan_t;   // kind: 0 done, 1 error, 2 both, 3 silent

  gexp_t gq[$];
  sexp_t sq[$];
  plan_t pq[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int m_last = NREQ - 1;
  int m_tcnt = 0;
  logic [31:0] wd [NREQ];
  logic [31:0] rd [NREQ];
  logic [4:0]  nmv[NREQ];
  logic        wrv[NREQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_fields();
    for (int i = 0; i < NREQ; i++) begin
      ifc.req_wdata[32*i +: 32] = wd[i];
      ifc.req_rdata[32*i +: 32] = rd[i];
      ifc.req_nm[5*i +: 5]      = nmv[i];
      ifc.req_wr[i]             = wrv[i];
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NREQ; i++) begin
      wd[i]  = $urandom;
      rd[i]  = $urandom;
      nmv[i] = 5'($urandom_range(1, 31));
      wrv[i] = 1'($urandom_range(0, 1));
    end
    apply_fields();
  endtask

  // Reference: scan last+1, last+2, ... modulo NREQ for the first requester.
  function automatic int rr_pick(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (m[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    return 0;
  endfunction

  task automatic expect_txn(input logic [NREQ-1:0] m, input int kind);
    int w;
    gexp_t g;
    sexp_t s;
    w = rr_pick(m);
    g.grant = '0; g.grant[w] = 1'b1;
    g.wr = wrv[w]; g.wdata = wd[w]; g.rdata = rd[w]; g.nm = nmv[w];
    gq.push_back(g);
    m_last = w;
    s.done = '0; s.err = '0;
    if (kind == 0) s.done[w] = 1'b1; else s.err[w] = 1'b1;
    if (kind == 3 && m_tcnt < 255) m_tcnt++;
    s.tcnt = 8'(m_tcnt);
    sq.push_back(s);
  endtask

  // One isolated transaction, issued from IDLE with fields already applied.
  task automatic run_txn(input logic [NREQ-1:0] m, input int kind, input int delay, input int hold,
                         input bit drop, input bit scramble);
    plan_t p;
    int    cnt;
    bit    seen;
    expect_txn(m, kind);
    p.kind = kind; p.delay = delay; p.hold = hold;
    pq.push_back(p);
    ifc.req_valid = m;
    @(negedge clk_in);
    check("grant_latency", ifc.grant != '0, 1);
    @(negedge clk_in);
    check("bus_en_latency", ifc.bus_en, 1);
    if (scramble) rand_fields();
    if (drop) ifc.req_valid = '0;
    cnt = 0; seen = 0;
    while (!seen && cnt < TO + 40) begin
      @(negedge clk_in);
      cnt++;
      if ((ifc.req_done | ifc.req_err) != '0) seen = 1;
    end
    check("status_seen", seen, 1);
    if (kind == 3) check("timeout_latency", cnt, TO);
    check("bus_en_off", ifc.bus_en, 0);
    check("busy_in_release", busy, 1);
    ifc.req_valid = '0;
    cnt = 0;
    while (busy && cnt < 20) begin
      @(negedge clk_in);
      cnt++;
    end
    check("return_idle", busy, 0);
  endtask

  // Engine model: answers each bus_en according to the next queued plan.
  initial begin
    plan_t p;
    ifc.bus_done  = 1'b0;
    ifc.bus_error = 1'b0;
    forever begin
      @(negedge clk_in);
      if (reset_n && ifc.bus_en && pq.size() > 0) begin
        p = pq.pop_front();
        repeat (p.delay) @(negedge clk_in);
        if (p.kind != 3) begin
          ifc.bus_done  = (p.kind == 0 || p.kind == 2);
          ifc.bus_error = (p.kind == 1 || p.kind == 2);
          repeat (p.hold) @(negedge clk_in);
          ifc.bus_done  = 1'b0;
          ifc.bus_error = 1'b0;
        end
        while (ifc.bus_en) @(negedge clk_in);
      end
    end
  end

  // Monitor: pops expectations whenever a grant starts or a status pulse appears.
  initial begin
    logic [NREQ-1:0] prev_grant;
    bit    saw_idle;
    bit    have_cur;
    gexp_t cur;
    sexp_t s;
    prev_grant = '0; saw_idle = 1; have_cur = 0;
    forever begin
      @(negedge clk_in);
      if (!reset_n) begin
        prev_grant = '0; saw_idle = 1; have_cur = 0;
      end else begin
        if (!busy) saw_idle = 1;
        if (ifc.grant != '0 && prev_grant == '0) begin
          if (gq.size() == 0) begin
            check("unexpected_grant", ifc.grant, 0);
          end else begin
            cur = gq.pop_front();
            have_cur = 1;
            check("grant", ifc.grant, cur.grant);
            check("bus_wr", ifc.bus_wr, cur.wr);
            check("bus_wdata", ifc.bus_wdata, cur.wdata);
            check("bus_rdata", ifc.bus_rdata, cur.rdata);
            check("bus_nm", ifc.bus_nm, cur.nm);
            check("idle_gap", saw_idle, 1);
            saw_idle = 0;
          end
        end else if (ifc.grant != '0 && have_cur) begin
          check("frozen_wdata", ifc.bus_wdata, cur.wdata);
          check("frozen_rdata", ifc.bus_rdata, cur.rdata);
          check("frozen_nm", {ifc.bus_wr, ifc.bus_nm}, {cur.wr, cur.nm});
        end
        if ((ifc.req_done | ifc.req_err) != '0) begin
          if (sq.size() == 0) begin
            check("unexpected_status", {ifc.req_done, ifc.req_err}, 0);
          end else begin
            s = sq.pop_front();
            check("req_done", ifc.req_done, s.done);
            check("req_err", ifc.req_err, s.err);
            check("timeout_cnt", timeout_cnt, s.tcnt);
          end
        end
        prev_grant = ifc.grant;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "bench did not complete");
  end

  // Stimulus.
  initial begin
    int cnt;
    logic [NREQ-1:0] m;
    ifc.req_valid = '0;
    rand_fields();
    #1;
    check("rst_grant", ifc.grant, 0);
    check("rst_status", {ifc.req_done, ifc.req_err}, 0);
    check("rst_bus_en", ifc.bus_en, 0);
    check("rst_busy", busy, 0);
    check("rst_tcnt", timeout_cnt, 0);
    check("rst_bus_fields", {ifc.bus_wr, ifc.bus_nm, ifc.bus_wdata, ifc.bus_rdata[15:0]}, 0);
    repeat (3) @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);

    // All four requesting continuously, done 5 cycles after bus_en: order 0,1,2,3,0.
    rand_fields();
    for (int n = 0; n < 5; n++) begin
      plan_t p;
      expect_txn(4'hF, 0);
      p.kind = 0; p.delay = 5; p.hold = 1;
      pq.push_back(p);
    end
    ifc.req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      cnt = 0;
      while (ifc.grant == '0 && cnt < 30) begin @(negedge clk_in); cnt++; end
      check("rr_grant_seen", ifc.grant != '0, 1);
      if (n == 4) ifc.req_valid = '0;
      cnt = 0;
      while (ifc.grant != '0 && cnt < 30) begin @(negedge clk_in); cnt++; end
      check("rr_grant_end", ifc.grant, 0);
    end
    cnt = 0;
    while (busy && cnt < 20) begin @(negedge clk_in); cnt++; end
    check("rr_idle", busy, 0);

    // Single requester 2 with a 3-cycle done.
    rand_fields();
    wd[2] = 32'h00D0_6875; nmv[2] = 5'd2;
    apply_fields();
    run_txn(4'b0100, 0, 1, 3, 0, 0);

    // Requester 1 with done and error together.
    rand_fields();
    run_txn(4'b0010, 2, 2, 1, 0, 0);

    // Requester 3 drops req_valid mid-WAIT while its inputs are scrambled.
    rand_fields();
    run_txn(4'b1000, 0, 6, 1, 1, 1);

    // Reset while in WAIT.
    rand_fields();
    expect_txn(4'b0100, 3);
    void'(sq.pop_back());
    begin
      plan_t p;
      p.kind = 3; p.delay = 0; p.hold = 1;
      pq.push_back(p);
    end
    ifc.req_valid = 4'b0100;
    repeat (5) @(negedge clk_in);
    #2 reset_n = 1'b0;
    #1;
    check("arst_bus_en", ifc.bus_en, 0);
    check("arst_grant", ifc.grant, 0);
    check("arst_busy", busy, 0);
    ifc.req_valid = '0;
    m_last = NREQ - 1;
    m_tcnt = 0;
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);
    check("arst_tcnt", timeout_cnt, 0);
    rand_fields();
    run_txn(4'hF, 0, 1, 1, 0, 0);

    // Randomized mix of done, error and both.
    for (int n = 0; n < 60; n++) begin
      rand_fields();
      m = 4'($urandom_range(1, 15));
      run_txn(m, $urandom_range(0, 2), $urandom_range(0, 8), $urandom_range(1, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Watchdog aborts, first count then saturation.
    rand_fields();
    run_txn(4'b0001, 3, 0, 1, 0, 0);
    check("tcnt_first", timeout_cnt, 1);
    for (int n = 0; n < 299; n++) begin
      rand_fields();
      m = 4'($urandom_range(1, 15));
      run_txn(m, 3, 0, 1, 0, 0);
    end
    check("tcnt_saturated", timeout_cnt, 255);

    repeat (3) @(negedge clk_in);
    check("grant_queue_drained", gq.size(), 0);
    check("status_queue_drained", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
